// File: rtl/serial_deframer.sv
// Serial deframer: hunts for a sync byte in an LSB-first bit stream,
// then delivers fixed-length payload frames with flywheel sync tracking.
module serial_deframer #(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FRAME_LEN  = 4,
    parameter int         MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       bit_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [BW-1:0] SYNC_SLOT = BW'(FRAME_LEN);
    localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_LIMIT);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state;
    logic [7:0]    sr;
    logic [7:0]    next_sr;
    logic [2:0]    bit_cnt;
    logic [2:0]    fill_cnt;
    logic [BW-1:0] byte_cnt;
    logic [MW-1:0] miss_cnt;
    logic [MW-1:0] miss_nxt;
    logic          sync_hit;

    assign next_sr  = {in_bit, sr[7:1]};
    assign miss_nxt = miss_cnt + 1'b1;
    assign sync_hit = (next_sr == SYNC_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            fill_cnt    <= '0;
            byte_cnt    <= '0;
            miss_cnt    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (bit_en) begin
                sr <= next_sr;
                if (fill_cnt != 3'd7)
                    fill_cnt <= fill_cnt + 3'd1;
                case (state)
                    HUNT: begin
                        // fill_cnt==7 means this bit is at least the 8th since reset
                        if (fill_cnt == 3'd7 && sync_hit) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt != SYNC_SLOT) begin
                                data_out    <= next_sr;
                                data_valid  <= 1'b1;
                                frame_start <= (byte_cnt == '0);
                                byte_cnt    <= byte_cnt + 1'b1;
                            end else begin
                                byte_cnt <= '0;
                                if (sync_hit) begin
                                    miss_cnt <= '0;
                                end else begin
                                    sync_err <= 1'b1;
                                    if (miss_nxt == MISS_MAX) begin
                                        state    <= HUNT;
                                        locked   <= 1'b0;
                                        miss_cnt <= '0;
                                    end else begin
                                        miss_cnt <= miss_nxt;
                                    end
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed frame scenarios plus a long random
// stream, all checked cycle by cycle against a bit-history reference model.
module tb_serial_deframer;

    localparam logic [7:0] SW = 8'hA5;
    localparam int FL = 4;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_bit = 1'b0;
    logic       bit_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    serial_deframer #(.SYNC_WORD(SW), .FRAME_LEN(FL), .MISS_LIMIT(ML)) dut (
        .clk(clk),
        .reset(reset),
        .in_bit(in_bit),
        .bit_en(bit_en),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_start(frame_start),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // reference model: bit history since reset, bits elapsed since lock
    bit   mq[$];
    int   nbits;
    int   nsince;
    int   misses;
    bit   mlocked;
    logic [7:0] exp_data;
    bit   exp_dv, exp_fs, exp_se, exp_lk;

    logic [7:0] got[$];
    int   nse;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit b);
        logic [7:0] v;
        int k;
        int slot;
        exp_dv = 0;
        exp_fs = 0;
        exp_se = 0;
        if (r) begin
            mq.delete();
            nbits = 0;
            nsince = 0;
            misses = 0;
            mlocked = 0;
            exp_data = 8'h00;
            exp_lk = 0;
            return;
        end
        if (!e) return;
        mq.push_back(b);
        if (mq.size() > 8) void'(mq.pop_front());
        nbits++;
        v = 8'h00;
        if (mq.size() == 8)
            for (int i = 0; i < 8; i++) v[i] = mq[i];
        if (!mlocked) begin
            if (nbits >= 8 && v == SW) begin
                mlocked = 1;
                nsince = 0;
                misses = 0;
            end
        end else begin
            nsince++;
            if (nsince % 8 == 0) begin
                k = nsince / 8 - 1;
                slot = k % (FL + 1);
                if (slot < FL) begin
                    exp_dv = 1;
                    exp_data = v;
                    exp_fs = (slot == 0);
                end else if (v == SW) begin
                    misses = 0;
                end else begin
                    exp_se = 1;
                    misses++;
                    if (misses == ML) begin
                        mlocked = 0;
                        misses = 0;
                    end
                end
            end
        end
        exp_lk = mlocked;
    endtask

    task automatic drive(input bit r, input bit e, input bit b);
        @(negedge clk);
        reset = r;
        bit_en = e;
        in_bit = b;
        model_step(r, e, b);
        started = 1'b1;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        if (started) begin
            #1;
            chk("data_valid", int'(data_valid), int'(exp_dv));
            chk("frame_start", int'(frame_start), int'(exp_fs));
            chk("sync_err", int'(sync_err), int'(exp_se));
            chk("locked", int'(locked), int'(exp_lk));
            chk("data_out", int'(data_out), int'(exp_data));
            if (data_valid) got.push_back(data_out);
            if (sync_err) nse++;
        end
    end

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, v[i]);
            if (gaps) drive(0, 0, 1'($urandom));
        end
    endtask

    task automatic lock_probe();
        logic [7:0] s;
        s = SW;
        for (int i = 0; i < 7; i++) drive(0, 1, s[i]);
        chk("lock_early", int'(locked), 0);
        drive(0, 1, s[7]);
        chk("lock_edge", int'(locked), 1);
    endtask

    task automatic start_case();
        drive(1, 1, 1'b1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_data", int'(data_out), 0);
        got.delete();
        nse = 0;
    endtask

    task automatic chk_list(input string nm, input logic [7:0] want[$]);
        chk({nm, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk(nm, int'(got[i]), int'(want[i]));
    endtask

    logic [7:0] w1[$];
    logic [7:0] w2[$];
    logic [7:0] s8;

    initial begin
        w1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        drive(1, 0, 0);

        // aligned stream
        start_case();
        lock_probe();
        for (int i = 0; i < 4; i++) send_byte(w1[i], 0);
        send_byte(SW, 0);
        for (int i = 4; i < 8; i++) send_byte(w1[i], 0);
        chk_list("s1_bytes", w1);
        chk("s1_sync_err", nse, 0);

        // three leading junk bits
        start_case();
        for (int i = 0; i < 3; i++) drive(0, 1, 1'($urandom));
        lock_probe();
        for (int i = 0; i < 4; i++) send_byte(w1[i], 0);
        send_byte(SW, 0);
        for (int i = 4; i < 8; i++) send_byte(w1[i], 0);
        chk_list("s2_bytes", w1);

        // isolated misses flywheel
        start_case();
        lock_probe();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) send_byte(8'(16 * f + i + 1), 0);
            send_byte((f % 2 == 0) ? 8'hA4 : SW, 0);
        end
        chk("s3_bytes", got.size(), 16);
        chk("s3_sync_err", nse, 2);
        chk("s3_locked", int'(locked), 1);

        // two consecutive misses drop lock
        start_case();
        lock_probe();
        for (int i = 0; i < 4; i++) send_byte(w1[i], 0);
        send_byte(8'hA4, 0);
        for (int i = 4; i < 8; i++) send_byte(w1[i], 0);
        send_byte(8'h5A, 0);
        chk("s4_lost", int'(locked), 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        chk("s4_hunt_bytes", got.size(), 8);
        send_byte(SW, 0);
        chk("s4_relock", int'(locked), 1);
        for (int i = 0; i < 4; i++) send_byte(w1[i], 0);
        w2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h11, 8'h22, 8'h33, 8'h44};
        chk_list("s4_bytes", w2);
        chk("s4_sync_err", nse, 2);

        // bit_en gaps
        start_case();
        send_byte(SW, 1);
        for (int i = 0; i < 4; i++) send_byte(w1[i], 1);
        send_byte(SW, 1);
        for (int i = 4; i < 8; i++) send_byte(w1[i], 1);
        chk_list("s5_bytes", w1);

        // reset mid-payload; stale bits must not complete a sync
        start_case();
        lock_probe();
        send_byte(8'h11, 0);
        s8 = SW;
        drive(0, 1, s8[0]);
        drive(1, 1, s8[1]);
        chk("s6_rst_locked", int'(locked), 0);
        for (int i = 1; i < 8; i++) drive(0, 1, s8[i]);
        chk("s6_no_lock", int'(locked), 0);
        lock_probe();
        send_byte(8'h3C, 0);
        chk("s6_byte", int'(data_out), 'h3C);

        // random frames, gaps, corruptions, slips, resets
        start_case();
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 49) == 0) drive(1, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 9) == 0)
                for (int j = 0; j < $urandom_range(1, 5); j++) drive(0, 1, 1'($urandom));
            s8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SW;
            for (int i = 0; i < 8; i++) begin
                while ($urandom_range(0, 3) == 0) drive(0, 0, 1'($urandom));
                drive(0, 1, s8[i]);
            end
            for (int b = 0; b < FL; b++) send_byte(8'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
